// File: rtl/nvram_upload.sv
// Upload-side NVRAM responder for the HPS ioctl channel: serves host reads during an
// NVRAM save session and tracks whether NVRAM changed since the last complete save.
module nvram_upload #(
  parameter int AW    = 10,
  parameter int SIZE  = 1024,
  parameter int LAT   = 1,
  parameter int INDEX = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] nv_addr,
  output logic          nv_rd,
  input  logic [7:0]    nv_q,
  input  logic          nv_cpu_wr,
  output logic          nvram_dirty,
  output logic          busy
);

  // state   | meaning
  // S_IDLE  | waiting for a host read strobe
  // S_FETCH | nv_rd is high, latency countdown begins
  // S_LAT   | remaining latency cycles until nv_q is valid
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAT} state_t;

  localparam logic [25:0]   SIZE_W = 26'(SIZE);
  localparam logic [AW-1:0] LAST   = AW'(SIZE - 1);
  localparam logic [1:0]    CNT_LD = 2'(LAT - 1);

  state_t        state, state_nx;
  logic [1:0]    cnt, cnt_nx;
  logic [7:0]    din_nx;
  logic          wait_nx;
  logic [AW-1:0] addr_nx;
  logic          rd_nx;
  logic          deliver;
  logic          sess, sess_q;
  logic          in_range;
  logic          last_done;

  assign sess     = ioctl_upload & (ioctl_index == 8'(INDEX));
  // full 25-bit compare so high address bits cannot alias into NVRAM
  assign in_range = {1'b0, ioctl_addr} < SIZE_W;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    din_nx   = ioctl_din;
    wait_nx  = ioctl_wait;
    addr_nx  = nv_addr;
    rd_nx    = 1'b0;
    deliver  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ioctl_rd && sess) begin
          if (in_range) begin
            addr_nx  = ioctl_addr[AW-1:0];
            rd_nx    = 1'b1;
            wait_nx  = 1'b1;
            cnt_nx   = CNT_LD;
            state_nx = S_FETCH;
          end else begin
            din_nx = 8'hFF;
          end
        end
      end
      S_FETCH, S_LAT: begin
        // an aborted session drops the byte in flight; ioctl_din keeps its old value
        if (!sess) begin
          wait_nx  = 1'b0;
          state_nx = S_IDLE;
        end else if (cnt == 2'd0) begin
          din_nx   = nv_q;
          wait_nx  = 1'b0;
          deliver  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx   = cnt - 2'd1;
          state_nx = S_LAT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      nv_addr    <= '0;
      nv_rd      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ioctl_din  <= din_nx;
      ioctl_wait <= wait_nx;
      nv_addr    <= addr_nx;
      nv_rd      <= rd_nx;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sess_q      <= 1'b0;
      last_done   <= 1'b0;
      nvram_dirty <= 1'b0;
    end else begin
      sess_q <= sess;
      if (sess && !sess_q) begin
        last_done <= 1'b0;
      end else if (deliver && (nv_addr == LAST)) begin
        last_done <= 1'b1;
      end
      // a CPU write racing the end of a complete save keeps the flag set
      if (nv_cpu_wr) begin
        nvram_dirty <= 1'b1;
      end else if (sess_q && !sess && last_done) begin
        nvram_dirty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nvram_upload.sv
// Bench for nvram_upload: three instances (LAT 1, 2, 3) on shared host stimulus,
// each backed by its own NVRAM read-pipeline model holding mem[a] = a[7:0] ^ 8'h5A.
module tb_nvram_upload;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        nv_cpu_wr;

  logic [7:0] din1, din2, din3;
  logic       wait1, wait2, wait3;
  logic [9:0] nva1, nva2, nva3;
  logic       nvrd1, nvrd2, nvrd3;
  logic [7:0] q1, q2, q3, q3a;
  logic       dirty1, dirty2, dirty3;
  logic       busy1, busy2, busy3;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] mem_f(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  assign q1 = mem_f(nva1);
  always @(posedge clk_sys) begin
    q2  <= mem_f(nva2);
    q3a <= mem_f(nva3);
    q3  <= q3a;
  end

  nvram_upload #(.AW(10), .SIZE(1024), .LAT(1), .INDEX(4)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(din1), .ioctl_wait(wait1), .nv_addr(nva1), .nv_rd(nvrd1),
    .nv_q(q1), .nv_cpu_wr(nv_cpu_wr), .nvram_dirty(dirty1), .busy(busy1));

  nvram_upload #(.AW(10), .SIZE(1024), .LAT(2), .INDEX(4)) dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(din2), .ioctl_wait(wait2), .nv_addr(nva2), .nv_rd(nvrd2),
    .nv_q(q2), .nv_cpu_wr(nv_cpu_wr), .nvram_dirty(dirty2), .busy(busy2));

  nvram_upload #(.AW(10), .SIZE(1024), .LAT(3), .INDEX(4)) dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(din3), .ioctl_wait(wait3), .nv_addr(nva3), .nv_rd(nvrd3),
    .nv_q(q3), .nv_cpu_wr(nv_cpu_wr), .nvram_dirty(dirty3), .busy(busy3));

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    logic        rd_exp;
    int          wait_cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // one host read on the LAT=1 instance; returns on the first cycle a new read may be driven
  task automatic rd1(input logic [24:0] a, input logic [7:0] exp_din, input logic exp_rd,
                     input int exp_wait, input string nm);
    int w;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    chk({nm, " nv_rd"}, 32'(nvrd1), 32'(exp_rd));
    if (exp_rd) chk({nm, " nv_addr"}, 32'(nva1), 32'(a[9:0]));
    w = 0;
    while (wait1 && w < 8) begin
      w++;
      step();
    end
    chk({nm, " wait cycles"}, 32'(w), 32'(exp_wait));
    chk({nm, " din"}, 32'(din1), 32'(exp_din));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    vecs[0] = '{25'h0000000, 8'h5A, 1'b1, 1};
    vecs[1] = '{25'h0000005, 8'h5F, 1'b1, 1};
    vecs[2] = '{25'h00003FF, 8'hA5, 1'b1, 1};
    vecs[3] = '{25'h0000400, 8'hFF, 1'b0, 0};
    vecs[4] = '{25'h00002AA, 8'hF0, 1'b1, 1};
    vecs[5] = '{25'h1000000, 8'hFF, 1'b0, 0};
    vecs[6] = '{25'h00001FF, 8'hA5, 1'b1, 1};
    vecs[7] = '{25'h1000005, 8'hFF, 1'b0, 0};
    vecs[8] = '{25'h00000C3, 8'h99, 1'b1, 1};

    reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd4;
    ioctl_rd = 1'b0; ioctl_addr = '0; nv_cpu_wr = 1'b0;
    step(); step();
    chk("reset din", 32'(din1), 32'h0);
    chk("reset wait", 32'(wait1), 32'h0);
    chk("reset nv_addr", 32'(nva1), 32'h0);
    chk("reset nv_rd", 32'(nvrd1), 32'h0);
    chk("reset busy", 32'(busy1), 32'h0);
    chk("reset dirty", 32'(dirty1), 32'h0);
    reset_n = 1'b1;
    step();

    ioctl_upload = 1'b1;
    step(); step();
    for (int i = 0; i < 9; i++)
      rd1(vecs[i].addr, vecs[i].din, vecs[i].rd_exp, vecs[i].wait_cyc, $sformatf("vec%0d", i));

    // read strobe outside the NVRAM session is ignored
    ioctl_index = 8'd3;
    ioctl_addr  = 25'h5;
    ioctl_rd    = 1'b1;
    step();
    ioctl_rd = 1'b0;
    chk("nosess nv_rd", 32'(nvrd1), 32'h0);
    chk("nosess wait", 32'(wait1), 32'h0);
    step();
    chk("nosess din", 32'(din1), 32'h99);
    ioctl_index = 8'd4;
    repeat (4) step();

    // CPU writes, full save, write racing the session end
    nv_cpu_wr = 1'b1; step(); nv_cpu_wr = 1'b0; step();
    nv_cpu_wr = 1'b1; step(); nv_cpu_wr = 1'b0; step();
    chk("dirty after writes", 32'(dirty1), 32'h1);
    for (int a = 0; a < 1024; a++) rd1(25'(a), mem_f(10'(a)), 1'b1, 1, "upload1");
    ioctl_upload = 1'b0;
    nv_cpu_wr    = 1'b1;
    step();
    nv_cpu_wr = 1'b0;
    chk("dirty set wins", 32'(dirty1), 32'h1);
    step();
    chk("dirty held after session", 32'(dirty1), 32'h1);

    // clean full save clears the flag on session end
    ioctl_upload = 1'b1;
    step();
    chk("dirty before clean save", 32'(dirty1), 32'h1);
    for (int a = 0; a < 1024; a++) rd1(25'(a), mem_f(10'(a)), 1'b1, 1, "upload2");
    chk("dirty before session end", 32'(dirty1), 32'h1);
    ioctl_upload = 1'b0;
    step();
    chk("dirty cleared", 32'(dirty1), 32'h0);
    repeat (3) step();

    // abort mid-fetch on the LAT=2 instance after 10 bytes
    ioctl_upload = 1'b1;
    step();
    nv_cpu_wr = 1'b1; step(); nv_cpu_wr = 1'b0; step();
    chk("abort dirty pre", 32'(dirty2), 32'h1);
    for (int a = 0; a < 10; a++) begin
      ioctl_addr = 25'(a);
      ioctl_rd   = 1'b1;
      step();
      ioctl_rd = 1'b0;
      w = 0;
      while (busy2 && w < 8) begin
        w++;
        step();
      end
      chk("lat2 busy cycles", 32'(w), 32'h2);
      chk("lat2 din", 32'(din2), 32'(mem_f(10'(a))));
    end
    ioctl_addr = 25'd10;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    chk("abort in flight", 32'(busy2), 32'h1);
    ioctl_upload = 1'b0;
    step();
    chk("abort busy", 32'(busy2), 32'h0);
    chk("abort wait", 32'(wait2), 32'h0);
    chk("abort din held", 32'(din2), 32'h53);
    step();
    chk("abort dirty kept", 32'(dirty2), 32'h1);
    repeat (3) step();

    // asynchronous reset in the middle of a LAT=3 fetch
    ioctl_upload = 1'b1;
    step();
    ioctl_addr = 25'h3FF;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    chk("lat3 pre-reset busy", 32'(busy3), 32'h1);
    chk("lat3 pre-reset nv_rd", 32'(nvrd3), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst din", 32'(din3), 32'h0);
    chk("async rst wait", 32'(wait3), 32'h0);
    chk("async rst nv_addr", 32'(nva3), 32'h0);
    chk("async rst nv_rd", 32'(nvrd3), 32'h0);
    chk("async rst busy", 32'(busy3), 32'h0);
    chk("async rst dirty", 32'(dirty3), 32'h0);
    step();
    reset_n = 1'b1;
    step();

    // LAT=3 single read of the last address
    ioctl_addr = 25'h3FF;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    chk("lat3 N+1 nv_rd", 32'(nvrd3), 32'h1);
    chk("lat3 N+1 wait", 32'(wait3), 32'h1);
    chk("lat3 N+1 nv_addr", 32'(nva3), 32'h3FF);
    step();
    chk("lat3 N+2 nv_rd", 32'(nvrd3), 32'h0);
    chk("lat3 N+2 wait", 32'(wait3), 32'h1);
    step();
    chk("lat3 N+3 wait", 32'(wait3), 32'h1);
    chk("lat3 N+3 din", 32'(din3), 32'h0);
    step();
    chk("lat3 N+4 wait", 32'(wait3), 32'h0);
    chk("lat3 N+4 din", 32'(din3), 32'hA5);
    chk("lat3 N+4 busy", 32'(busy3), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
